pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the RV32I 5-stage core. It drives the enables and flushes of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Stall causes: load-use hazards, instruction-memory wait, data-memory wait, and a branch/jump redirect that arrives while a fetch is still outstanding. It also keeps stall, flush and timeout status for debug.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DMEM_WAIT  = 2'd1,
    REDIR_WAIT = 2'd2
  } ctrl_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Control word order: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
  localparam logic [6:0] CTL_FREEZE   = 7'b0000000;
  localparam logic [6:0] CTL_RUN      = 7'b1111100;
  localparam logic [6:0] CTL_REDIRECT = 7'b1111111;
  localparam logic [6:0] CTL_LOAD_USE = 7'b0011101;
  localparam logic [6:0] CTL_IFETCH   = 7'b0111110;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush sequencing for the 5-stage RV32I pipeline with debug status
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             ex_redirect,
  input  logic             imem_req,
  input  logic             imem_ack,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam int WW = $clog2(WAIT_LIMIT + 1);

  ctrl_state_t   state;
  ctrl_state_t   nxt;
  logic          dpend;
  logic          ipend;
  logic          mem_pend;
  logic          load_use;
  logic          run_eval;
  logic          flush_inc;
  logic [6:0]    ctl;
  logic [6:0]    ctl_out;
  logic [WW-1:0] wait_cnt;

  assign dpend    = dmem_req & ~dmem_ack;
  assign ipend    = imem_req & ~imem_ack;
  assign mem_pend = dpend | ipend;

  assign load_use = ex_mem_read & ex_reg_write & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  // RUN and the release cycle of DMEM_WAIT share the same redirect/load-use/fetch priority.
  always_comb begin
    ctl       = CTL_FREEZE;
    nxt       = state;
    flush_inc = 1'b0;
    run_eval  = 1'b0;
    case (state)
      RUN: begin
        if (dpend) nxt = DMEM_WAIT;
        else       run_eval = 1'b1;
      end
      DMEM_WAIT: begin
        if (!dpend) run_eval = 1'b1;
      end
      REDIR_WAIT: begin
        if (imem_ack) begin
          ctl       = CTL_REDIRECT;
          flush_inc = 1'b1;
          nxt       = RUN;
        end
      end
      default: nxt = RUN;
    endcase

    if (run_eval) begin
      nxt = RUN;
      if (ex_redirect && ipend) begin
        nxt = REDIR_WAIT;
      end else if (ex_redirect) begin
        ctl       = CTL_REDIRECT;
        flush_inc = 1'b1;
      end else if (load_use) begin
        ctl = CTL_LOAD_USE;
      end else if (ipend) begin
        ctl = CTL_IFETCH;
      end else begin
        ctl = CTL_RUN;
      end
    end
  end

  assign ctl_out = rst ? CTL_FREEZE : ctl;
  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush} = ctl_out;
  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      mem_timeout <= 1'b0;
    end else begin
      state <= nxt;
      if (mem_pend && (wait_cnt >= WW'(WAIT_LIMIT - 1))) mem_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~pc_en),
    .clr (1'b0),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .clr (1'b0),
    .q   (flush_count)
  );

  sat_counter #(.W(WW)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mem_pend),
    .clr (~mem_pend),
    .q   (wait_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int CW = 4;
  localparam logic [6:0] E_FREEZE = 7'b0000000;
  localparam logic [6:0] E_RUN    = 7'b1111100;
  localparam logic [6:0] E_REDIR  = 7'b1111111;
  localparam logic [6:0] E_LU     = 7'b0011101;
  localparam logic [6:0] E_IF     = 7'b0111110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write, ex_redirect;
  logic imem_req, imem_ack, dmem_req, dmem_ack;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic [1:0] state_o;
  logic [CW-1:0] stall_cycles, flush_count;
  logic mem_timeout;
  logic [6:0] ctl;

  int vecs = 0;
  int errs = 0;

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CW), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_redirect(ex_redirect),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .state_o(state_o), .stall_cycles(stall_cycles), .flush_count(flush_count),
    .mem_timeout(mem_timeout)
  );

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_redirect = 1'b0;
    imem_req = 1'b0; imem_ack = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
    id_rs1 = rs1; id_uses_rs1 = use1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    dmem_req = 1'b1; ex_redirect = 1'b1; imem_req = 1'b1;
    #1;
    vecs++; if (ctl !== E_FREEZE) begin errs++; $display("FAIL reset_ctl got=%b exp=%b", ctl, E_FREEZE); end
    tick(); tick();
    vecs++; if (state_o !== 2'd0) begin errs++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    vecs++; if (stall_cycles !== 4'd0 || flush_count !== 4'd0 || mem_timeout !== 1'b0) begin
      errs++; $display("FAIL reset_status got=%0d/%0d/%b exp=0/0/0", stall_cycles, flush_count, mem_timeout);
    end
    idle();
    rst = 1'b0;
    #1;
    vecs++; if (ctl !== E_RUN) begin errs++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, E_RUN); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load(5'd5, 5'd5, 1'b1);
    #1;
    vecs++; if (ctl !== E_LU) begin errs++; $display("FAIL lu_ctl got=%b exp=%b", ctl, E_LU); end
    tick();
    vecs++; if (stall_cycles !== 4'd1) begin errs++; $display("FAIL lu_stall got=%0d exp=1", stall_cycles); end
    idle();
    #1;
    vecs++; if (ctl !== E_RUN) begin errs++; $display("FAIL lu_after_ctl got=%b exp=%b", ctl, E_RUN); end
    tick();
    set_load(5'd0, 5'd0, 1'b1);
    #1;
    vecs++; if (ctl !== E_RUN) begin errs++; $display("FAIL lu_x0_ctl got=%b exp=%b", ctl, E_RUN); end
    set_load(5'd9, 5'd9, 1'b0);
    #1;
    vecs++; if (ctl !== E_RUN) begin errs++; $display("FAIL lu_unused_ctl got=%b exp=%b", ctl, E_RUN); end
    set_load(5'd7, 5'd3, 1'b0);
    id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #1;
    vecs++; if (ctl !== E_LU) begin errs++; $display("FAIL lu_rs2_ctl got=%b exp=%b", ctl, E_LU); end
    ex_reg_write = 1'b0;
    #1;
    vecs++; if (ctl !== E_RUN) begin errs++; $display("FAIL lu_nowrite_ctl got=%b exp=%b", ctl, E_RUN); end
    tick();
    vecs++; if (stall_cycles !== 4'd1) begin errs++; $display("FAIL lu_stall_total got=%0d exp=1", stall_cycles); end
  endtask

  task automatic test_redirect();
    do_reset();
    ex_redirect = 1'b1;
    #1;
    vecs++; if (ctl !== E_REDIR) begin errs++; $display("FAIL redir_ctl got=%b exp=%b", ctl, E_REDIR); end
    tick();
    idle();
    #1;
    vecs++; if (flush_count !== 4'd1 || state_o !== 2'd0 || stall_cycles !== 4'd0) begin
      errs++; $display("FAIL redir_status got=%0d/%0d/%0d exp=1/0/0", flush_count, state_o, stall_cycles);
    end
  endtask

  task automatic test_ifetch_wait();
    do_reset();
    imem_req = 1'b1;
    #1;
    vecs++; if (ctl !== E_IF) begin errs++; $display("FAIL ifetch_ctl got=%b exp=%b", ctl, E_IF); end
    tick();
    imem_ack = 1'b1;
    #1;
    vecs++; if (ctl !== E_RUN || state_o !== 2'd0) begin
      errs++; $display("FAIL ifetch_ack got=%b/%0d exp=%b/0", ctl, state_o, E_RUN);
    end
    tick();
    vecs++; if (stall_cycles !== 4'd1) begin errs++; $display("FAIL ifetch_stall got=%0d exp=1", stall_cycles); end
  endtask

  task automatic test_dmem_wait();
    do_reset();
    dmem_req = 1'b1;
    #1;
    vecs++; if (ctl !== E_FREEZE || state_o !== 2'd0) begin
      errs++; $display("FAIL dmem_c1 got=%b/%0d exp=%b/0", ctl, state_o, E_FREEZE);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++; if (ctl !== E_FREEZE || state_o !== 2'd1) begin
        errs++; $display("FAIL dmem_hold%0d got=%b/%0d exp=%b/1", i, ctl, state_o, E_FREEZE);
      end
    end
    tick();
    dmem_ack = 1'b1;
    #1;
    vecs++; if (ctl !== E_RUN || state_o !== 2'd1) begin
      errs++; $display("FAIL dmem_ack got=%b/%0d exp=%b/1", ctl, state_o, E_RUN);
    end
    tick();
    idle();
    #1;
    vecs++; if (state_o !== 2'd0 || stall_cycles !== 4'd3 || mem_timeout !== 1'b0) begin
      errs++; $display("FAIL dmem_done got=%0d/%0d/%b exp=0/3/0", state_o, stall_cycles, mem_timeout);
    end
  endtask

  task automatic test_redir_wait();
    do_reset();
    ex_redirect = 1'b1; imem_req = 1'b1;
    #1;
    vecs++; if (ctl !== E_FREEZE || state_o !== 2'd0) begin
      errs++; $display("FAIL rw_c1 got=%b/%0d exp=%b/0", ctl, state_o, E_FREEZE);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++; if (ctl !== E_FREEZE || state_o !== 2'd2) begin
        errs++; $display("FAIL rw_hold%0d got=%b/%0d exp=%b/2", i, ctl, state_o, E_FREEZE);
      end
    end
    tick();
    imem_ack = 1'b1;
    #1;
    vecs++; if (ctl !== E_REDIR) begin errs++; $display("FAIL rw_ack_ctl got=%b exp=%b", ctl, E_REDIR); end
    tick();
    idle();
    #1;
    vecs++; if (state_o !== 2'd0 || flush_count !== 4'd1 || stall_cycles !== 4'd3 || ctl !== E_RUN) begin
      errs++; $display("FAIL rw_done got=%0d/%0d/%0d/%b exp=0/1/3/%b", state_o, flush_count, stall_cycles, ctl, E_RUN);
    end
  endtask

  task automatic test_dmem_to_redir();
    do_reset();
    dmem_req = 1'b1; ex_redirect = 1'b1; imem_req = 1'b1;
    tick();
    dmem_req = 1'b0;
    #1;
    vecs++; if (ctl !== E_FREEZE || state_o !== 2'd1) begin
      errs++; $display("FAIL d2r_release got=%b/%0d exp=%b/1", ctl, state_o, E_FREEZE);
    end
    tick();
    vecs++; if (state_o !== 2'd2) begin errs++; $display("FAIL d2r_state got=%0d exp=2", state_o); end
    imem_ack = 1'b1;
    #1;
    vecs++; if (ctl !== E_REDIR) begin errs++; $display("FAIL d2r_ack got=%b exp=%b", ctl, E_REDIR); end
    tick();
    vecs++; if (flush_count !== 4'd1 || state_o !== 2'd0) begin
      errs++; $display("FAIL d2r_done got=%0d/%0d exp=1/0", flush_count, state_o);
    end
  endtask

  task automatic test_timeout_and_reset();
    do_reset();
    dmem_req = 1'b1;
    tick(); tick(); tick();
    vecs++; if (mem_timeout !== 1'b0) begin errs++; $display("FAIL to_early got=%b exp=0", mem_timeout); end
    tick();
    vecs++; if (mem_timeout !== 1'b1) begin errs++; $display("FAIL to_set got=%b exp=1", mem_timeout); end
    dmem_ack = 1'b1;
    tick();
    idle();
    tick();
    vecs++; if (mem_timeout !== 1'b1 || state_o !== 2'd0) begin
      errs++; $display("FAIL to_sticky got=%b/%0d exp=1/0", mem_timeout, state_o);
    end
    dmem_req = 1'b1; ex_redirect = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    vecs++; if (state_o !== 2'd0 || mem_timeout !== 1'b0 || stall_cycles !== 4'd0 || flush_count !== 4'd0 || ctl !== E_FREEZE) begin
      errs++; $display("FAIL to_rst got=%0d/%b/%0d/%0d/%b exp=0/0/0/0/%b", state_o, mem_timeout, stall_cycles, flush_count, ctl, E_FREEZE);
    end
    idle();
    rst = 1'b0;
    tick();
    vecs++; if (state_o !== 2'd0 || flush_count !== 4'd0) begin
      errs++; $display("FAIL to_dropped got=%0d/%0d exp=0/0", state_o, flush_count);
    end
  endtask

  task automatic test_combined();
    do_reset();
    dmem_req = 1'b1; ex_redirect = 1'b1;
    set_load(5'd6, 5'd6, 1'b1);
    #1;
    vecs++; if (ctl !== E_FREEZE) begin errs++; $display("FAIL comb_c1 got=%b exp=%b", ctl, E_FREEZE); end
    tick();
    vecs++; if (ctl !== E_FREEZE || state_o !== 2'd1) begin
      errs++; $display("FAIL comb_c2 got=%b/%0d exp=%b/1", ctl, state_o, E_FREEZE);
    end
    tick();
    dmem_ack = 1'b1;
    #1;
    vecs++; if (ctl !== E_REDIR) begin errs++; $display("FAIL comb_ack got=%b exp=%b", ctl, E_REDIR); end
    tick();
    idle();
    #1;
    vecs++; if (flush_count !== 4'd1 || stall_cycles !== 4'd2 || state_o !== 2'd0) begin
      errs++; $display("FAIL comb_done got=%0d/%0d/%0d exp=1/2/0", flush_count, stall_cycles, state_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_load(5'd4, 5'd4, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    vecs++; if (stall_cycles !== 4'd15) begin errs++; $display("FAIL sat_stall_max got=%0d exp=15", stall_cycles); end
    for (int i = 0; i < 5; i++) tick();
    vecs++; if (stall_cycles !== 4'd15) begin errs++; $display("FAIL sat_stall_hold got=%0d exp=15", stall_cycles); end
    idle();
    ex_redirect = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    vecs++; if (flush_count !== 4'd15 || stall_cycles !== 4'd15) begin
      errs++; $display("FAIL sat_flush got=%0d/%0d exp=15/15", flush_count, stall_cycles);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_ifetch_wait();
    test_dmem_wait();
    test_redir_wait();
    test_dmem_to_redir();
    test_timeout_and_reset();
    test_combined();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
